// File: rtl/dbg_bridge_pkg.sv
// Shared constants and state encoding for the UART debug-bridge byte protocol.
// Used by both the host initiator and the remote bridge side.
package dbg_bridge_pkg;

  localparam logic [7:0] REQ_WRITE = 8'h10;
  localparam logic [7:0] REQ_READ  = 8'h11;

  // A 63-word burst is the longest the 8-bit length byte can describe.
  localparam logic [7:0] LEN_MAX   = 8'd252;

  localparam int unsigned STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_LEN    = 4'd2,
    ST_ADDR0  = 4'd3,
    ST_ADDR1  = 4'd4,
    ST_ADDR2  = 4'd5,
    ST_ADDR3  = 4'd6,
    ST_WFETCH = 4'd7,
    ST_WBYTE  = 4'd8,
    ST_RBYTE  = 4'd9,
    ST_RPUSH  = 4'd10,
    ST_DONE   = 4'd11
  } state_e;

  // Length byte on the wire is the burst size in bytes.
  function automatic logic [7:0] len_byte(input logic [5:0] words);
    return {words, 2'b00};
  endfunction

endpackage

// File: rtl/dbg_bridge_host_timeout.sv
// Loadable watchdog: counts enabled cycles since the last clear and pulses
// expire_o when the count reaches limit_i-1. A limit of 0 never expires.
module dbg_bridge_host_timeout #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && !clear_i && (limit_i != '0) &&
                    (count_q == (limit_i - 1'b1));

endmodule

// File: rtl/dbg_bridge_host.sv
// Host-side initiator: turns word read/write bursts into cmd/len/addr/data
// byte streams for a remote debug bridge and reassembles read words.
module dbg_bridge_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  REQ_WRITE      = dbg_bridge_pkg::REQ_WRITE,
  parameter logic [7:0]  REQ_READ       = dbg_bridge_pkg::REQ_READ
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [5:0]  req_words_i,
  input  logic        wdata_valid_i,
  input  logic [31:0] wdata_i,
  output logic        wdata_ready_o,
  output logic        rdata_valid_o,
  output logic [31:0] rdata_o,
  input  logic        rdata_ready_i,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_accept_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_accept_o
);

  import dbg_bridge_pkg::*;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q,  addr_d;
  logic [5:0]  words_q, words_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q,   idx_d;
  logic        err_q,   err_d;

  logic        tmo_clear;
  logic        tmo_enable;
  logic        tmo_expire;

  // The watchdog only runs while waiting for read bytes; any byte restarts it.
  assign tmo_enable = (state_q == ST_RBYTE);
  assign tmo_clear  = !tmo_enable || rx_valid_i;

  dbg_bridge_host_timeout #(
    .WIDTH (32)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .limit_i  (32'(TIMEOUT_CYCLES)),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expire_o (tmo_expire)
  );

  // NOTE: every output and next-state signal gets a default before the case,
  // so no branch can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    words_d       = words_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    err_d         = err_q;
    req_ready_o   = 1'b0;
    tx_valid_o    = 1'b0;
    tx_data_o     = 8'h00;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_o       = 32'h0;
    rx_accept_o   = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        // Stray bytes are drained while idle, but not while reset is held.
        rx_accept_o = rst_i;
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = {req_addr_i[31:2], 2'b00};
          words_d = req_words_i;
          if (req_words_i == 6'd0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_CMD;
          end
        end
      end

      ST_CMD: begin
        tx_valid_o = 1'b1;
        tx_data_o  = write_q ? REQ_WRITE : REQ_READ;
        if (tx_accept_i) state_d = ST_LEN;
      end

      ST_LEN: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_byte(words_q);
        if (tx_accept_i) state_d = ST_ADDR0;
      end

      ST_ADDR0: begin
        tx_valid_o = 1'b1;
        tx_data_o  = addr_q[31:24];
        if (tx_accept_i) state_d = ST_ADDR1;
      end

      ST_ADDR1: begin
        tx_valid_o = 1'b1;
        tx_data_o  = addr_q[23:16];
        if (tx_accept_i) state_d = ST_ADDR2;
      end

      ST_ADDR2: begin
        tx_valid_o = 1'b1;
        tx_data_o  = addr_q[15:8];
        if (tx_accept_i) state_d = ST_ADDR3;
      end

      ST_ADDR3: begin
        tx_valid_o = 1'b1;
        tx_data_o  = addr_q[7:0];
        if (tx_accept_i) begin
          idx_d   = 2'd0;
          state_d = write_q ? ST_WFETCH : ST_RBYTE;
        end
      end

      ST_WFETCH: begin
        wdata_ready_o = wdata_valid_i;
        if (wdata_valid_i) begin
          shift_d = wdata_i;
          idx_d   = 2'd0;
          state_d = ST_WBYTE;
        end
      end

      ST_WBYTE: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shift_q[7:0];
        if (tx_accept_i) begin
          shift_d = {8'h00, shift_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            words_d = (words_q != 6'd0) ? words_q - 6'd1 : 6'd0;
            state_d = (words_q <= 6'd1) ? ST_DONE : ST_WFETCH;
          end
        end
      end

      ST_RBYTE: begin
        rx_accept_o = 1'b1;
        if (rx_valid_i) begin
          unique case (idx_q)
            2'd0: shift_d[7:0]   = rx_data_i;
            2'd1: shift_d[15:8]  = rx_data_i;
            2'd2: shift_d[23:16] = rx_data_i;
            2'd3: shift_d[31:24] = rx_data_i;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_RPUSH;
        end else if (tmo_expire) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end

      ST_RPUSH: begin
        rdata_valid_o = 1'b1;
        rdata_o       = shift_q;
        if (rdata_ready_i) begin
          words_d = (words_q != 6'd0) ? words_q - 6'd1 : 6'd0;
          state_d = (words_q <= 6'd1) ? ST_DONE : ST_RBYTE;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      words_q <= 6'd0;
      shift_q <= 32'h0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbg_bridge_host.sv
// Scoreboard bench for dbg_bridge_host: expected tx bytes and read words are
// queued when stimulus is issued and compared as the DUT hands them out.
module tb_dbg_bridge_host;

  localparam int unsigned TMO = 16;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [5:0]  req_words_i;
  logic        wdata_valid_i;
  logic [31:0] wdata_i;
  logic        wdata_ready_o;
  logic        rdata_valid_o;
  logic [31:0] rdata_o;
  logic        rdata_ready_i;
  logic        done_o;
  logic        err_o;
  logic        busy_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_accept_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_accept_o;

  dbg_bridge_host #(
    .TIMEOUT_CYCLES (TMO),
    .REQ_WRITE      (8'h10),
    .REQ_READ       (8'h11)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_addr_i    (req_addr_i),
    .req_words_i   (req_words_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_i       (wdata_i),
    .wdata_ready_o (wdata_ready_o),
    .rdata_valid_o (rdata_valid_o),
    .rdata_o       (rdata_o),
    .rdata_ready_i (rdata_ready_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .busy_o        (busy_o),
    .tx_valid_o    (tx_valid_o),
    .tx_data_o     (tx_data_o),
    .tx_accept_i   (tx_accept_i),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .rx_accept_o   (rx_accept_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cyc_rx   = 0;
  int cyc_done = 0;
  int tx_seen  = 0;
  int done_cnt = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  logic [7:0]  rx_q[$];
  logic [31:0] wd_q[$];

  bit   rx_en     = 1'b0;
  bit   tx_toggle = 1'b0;
  bit   rx_take;
  bit   wd_take;
  bit   tx_pend   = 1'b0;
  logic [7:0] tx_prev;
  logic [7:0] eb;
  logic [31:0] ew;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // tx acceptance pattern: always ready, or alternating 1-0-1-0.
  initial begin
    tx_accept_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      tx_accept_i = tx_toggle ? ~tx_accept_i : 1'b1;
    end
  end

  // rx byte source fed from rx_q.
  initial begin
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      rx_take = rx_valid_i && rx_accept_o;
      if (rx_take) cyc_rx = cyc;
      @(posedge clk_i);
      #1;
      if (rx_take && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_valid_i = rx_en && (rx_q.size() > 0);
      rx_data_i  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  // Write-word source fed from wd_q.
  initial begin
    wdata_valid_i = 1'b0;
    wdata_i       = 32'h0;
    forever begin
      @(negedge clk_i);
      wd_take = wdata_valid_i && wdata_ready_o;
      @(posedge clk_i);
      #1;
      if (wd_take && wd_q.size() > 0) void'(wd_q.pop_front());
      wdata_valid_i = (wd_q.size() > 0);
      wdata_i       = (wd_q.size() > 0) ? wd_q[0] : 32'h0;
    end
  end

  // Output monitor: tx byte order and hold, read words, done pulses.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      if (tx_pend) begin
        check("tx_hold_valid", {31'h0, tx_valid_o}, 32'h1);
        check("tx_hold_data", {24'h0, tx_data_o}, {24'h0, tx_prev});
      end
      if (tx_valid_o && tx_accept_i) begin
        eb = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
        check("tx_byte", {24'h0, tx_data_o}, {24'h0, eb});
        tx_seen++;
      end
      tx_pend = tx_valid_o && !tx_accept_i;
      tx_prev = tx_data_o;
      if (rdata_valid_o && rdata_ready_i) begin
        ew = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hxxxx_xxxx;
        check("rdata", rdata_o, ew);
      end
      if (done_o) done_cnt++;
    end else begin
      tx_pend = 1'b0;
    end
  end

  task automatic push_hdr(input logic w, input logic [31:0] a, input int n);
    logic [31:0] al;
    al = a & ~32'h3;
    exp_tx.push_back(w ? 8'h10 : 8'h11);
    exp_tx.push_back(8'(n * 4));
    exp_tx.push_back(al[31:24]);
    exp_tx.push_back(al[23:16]);
    exp_tx.push_back(al[15:8]);
    exp_tx.push_back(al[7:0]);
  endtask

  task automatic push_wword(input logic [31:0] d);
    wd_q.push_back(d);
    for (int b = 0; b < 4; b++) exp_tx.push_back(d[8*b +: 8]);
  endtask

  task automatic push_rword(input logic [31:0] d);
    exp_rd.push_back(d);
    for (int b = 0; b < 4; b++) rx_q.push_back(d[8*b +: 8]);
  endtask

  task automatic send_req(input logic w, input logic [31:0] a, input logic [5:0] n);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_words_i = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (req_ready_o) break;
    end
    check("req_ready", {31'h0, req_ready_o}, 32'h1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    rx_en       = 1'b1;
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (done_o) break;
    end
    check({tag, "_done"}, {31'h0, done_o}, 32'h1);
    check({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    cyc_done = cyc;
    @(negedge clk_i);
    check({tag, "_after"}, {30'h0, done_o, req_ready_o}, 32'h1);
    check({tag, "_tx_left"}, exp_tx.size(), 0);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
    rx_en = 1'b0;
  endtask

  int ok;
  int start;
  int d0;

  initial begin
    rst_i         = 1'b0;
    req_valid_i   = 1'b0;
    req_write_i   = 1'b0;
    req_addr_i    = 32'h0;
    req_words_i   = 6'd0;
    rdata_ready_i = 1'b1;

    // Reset values while reset is held.
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ctrl", {24'h0, req_ready_o, busy_o, tx_valid_o, wdata_ready_o,
                         rdata_valid_o, done_o, err_o, rx_accept_o}, 32'h80);
    check("reset_tx_data", {24'h0, tx_data_o}, 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Single-word write with literal wire image.
    foreach (exp_tx[i]) ;
    exp_tx = '{8'h10, 8'h04, 8'h00, 8'h00, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wd_q.push_back(32'hDEADBEEF);
    send_req(1'b1, 32'h0000_1003, 6'd1);
    check("first_tx_latency", {31'h0, tx_valid_o}, 32'h1);
    wait_done("wr1", 1'b0, 100);

    // Two-word read.
    exp_tx = '{8'h11, 8'h08, 8'h80, 8'h00, 8'h00, 8'h00};
    rx_q   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_rd = '{32'h44332211, 32'h88776655};
    send_req(1'b0, 32'h8000_0000, 6'd2);
    wait_done("rd2", 1'b0, 200);

    // Write under alternating tx acceptance.
    tx_toggle = 1'b1;
    push_hdr(1'b1, 32'h0000_ABCF, 2);
    push_wword($urandom);
    push_wword($urandom);
    send_req(1'b1, 32'h0000_ABCF, 6'd2);
    wait_done("wr_toggle", 1'b0, 300);
    tx_toggle = 1'b0;

    // Read held off by rdata_ready_i low for 20 cycles.
    rdata_ready_i = 1'b0;
    push_hdr(1'b0, 32'h4000_0012, 2);
    push_rword($urandom);
    push_rword($urandom);
    send_req(1'b0, 32'h4000_0012, 6'd2);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (rdata_valid_o) break;
    end
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (rdata_valid_o && !rx_accept_o) ok++;
    end
    check("rpush_hold", ok, 20);
    check("rx_not_lost", rx_q.size(), 4);
    @(posedge clk_i);
    #1;
    rdata_ready_i = 1'b1;
    wait_done("rd_hold", 1'b0, 200);

    // Read timeout after two bytes.
    push_hdr(1'b0, 32'h0000_0100, 1);
    rx_q = '{8'hA1, 8'hB2};
    send_req(1'b0, 32'h0000_0100, 6'd1);
    wait_done("tmo", 1'b1, 200);
    check("tmo_latency", cyc_done - (cyc_rx + 1), TMO);

    // Zero-length request: no bytes, error pulse.
    send_req(1'b1, 32'h0000_0010, 6'd0);
    wait_done("zero", 1'b1, 20);

    // Stray rx bytes are drained while idle.
    rx_q  = '{8'h5A, 8'hC3};
    rx_en = 1'b1;
    repeat (6) @(negedge clk_i);
    check("idle_rx_drain", rx_q.size(), 0);
    check("idle_busy", {31'h0, busy_o}, 32'h0);
    rx_en = 1'b0;

    // Longest burst: 63 words, length byte 252.
    push_hdr(1'b1, 32'hFFFF_FFFD, 63);
    for (int w = 0; w < 63; w++) push_wword($urandom);
    send_req(1'b1, 32'hFFFF_FFFD, 6'd63);
    wait_done("wr_max", 1'b0, 700);

    // Asynchronous reset in the middle of a write data byte.
    push_hdr(1'b1, 32'h0000_0020, 2);
    push_wword(32'h0102_0304);
    push_wword(32'h0506_0708);
    start = tx_seen;
    send_req(1'b1, 32'h0000_0020, 6'd2);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i);
      if (tx_seen >= start + 8) break;
    end
    #2;
    rst_i = 1'b0;
    #1;
    check("midreset_ctrl", {24'h0, req_ready_o, busy_o, tx_valid_o, wdata_ready_o,
                            rdata_valid_o, done_o, err_o, rx_accept_o}, 32'h80);
    check("midreset_tx_data", {24'h0, tx_data_o}, 32'h0);
    exp_tx.delete();
    wd_q.delete();
    rx_en = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("midreset_no_done", done_cnt, d0);
    check("midreset_idle", {30'h0, busy_o, req_ready_o}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
